mips_instr_sequencer: RTL and testbench
=======================================

Name: mips_instr_sequencer

Overview:
Parametrised instruction sequencer that replaces hand-timed instruction pokes into the processor's instruction port. It holds a loadable program buffer, issues one instruction per cycle (or one per step request), and supports stalls, looping and a NOP drain tail. It sits between the bench/loader and the processor's `instr` input in the top-level wrapper.

Parameters:
- DATA_W, 32: instruction width.
- DEPTH, 64: program buffer entries.
- ADDR_W, $clog2(DEPTH): buffer index width.
- NOP_WORD, 32'h00000000: word driven when no instruction is issued.
- DRAIN_CYCLES, 12: NOP cycles issued after the last instruction before `done`; legal range 0 to 255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- load_en  in  1  write load_data into buffer[load_addr]; accepted only in IDLE or DONE
- load_addr  in  ADDR_W  buffer write index
- load_data  in  DATA_W  instruction word to store
- prog_len  in  ADDR_W+1  number of instructions, 1..DEPTH; sampled on start
- start  in  1  begin execution from index 0
- step_mode  in  1  1 = issue only on step pulses; sampled on start
- step  in  1  single-step request; used only when step_mode is latched
- loop_en  in  1  wrap to index 0 after the last instruction instead of draining; sampled on start
- stall  in  1  hold the current issue and do not advance
- abort  in  1  go directly to DRAIN from RUN or STEP
- instr  out  DATA_W  instruction presented to the processor (registered)
- instr_valid  out  1  instr holds a program word this cycle
- pc_idx  out  ADDR_W  buffer index of the current instr
- busy  out  1  state is RUN, STEP or DRAIN
- done  out  1  one-cycle pulse on entry to DONE
- issued_cnt  out  16  count of valid issues since start; saturates at 16'hFFFF

Behaviour:
- Reset values: instr=NOP_WORD, instr_valid=0, pc_idx=0, busy=0, done=0, issued_cnt=0, state=IDLE. Buffer contents are not reset.
- States and transitions:
  - IDLE: start → RUN if step_mode=0, otherwise STEP.
  - RUN: issues buffer[idx] every cycle in which stall=0.
  - STEP: issues buffer[idx] for exactly one cycle per step pulse with stall=0. instr returns to NOP_WORD with instr_valid=0 in the following cycle.
  - After the issue at idx = prog_len-1: if loop_en=1, idx wraps to 0 and the state is unchanged; otherwise go to DRAIN.
  - DRAIN: drives NOP_WORD with instr_valid=0 for DRAIN_CYCLES cycles, then goes to DONE. With DRAIN_CYCLES=0, go to DONE on the next cycle.
  - DONE: done pulses high for one cycle. start restarts, with issued_cnt cleared.
- Latency: instr/instr_valid are registered. The first instruction appears in the cycle after the start edge. The buffer read is registered, so the buffer is synchronous-read.
- Stall: instr, instr_valid, pc_idx and issued_cnt all hold. A stall has no effect in IDLE, DRAIN or DONE.
- Abort: takes effect on the next edge. The in-flight word is dropped, instr becomes NOP_WORD and the drain count starts. abort has priority over step and stall.
- start while busy: ignored.
- load_en while busy: ignored, and the buffer is unchanged.
- Load and start in the same cycle (in IDLE or DONE): the write completes first, and execution sees the new word.
- prog_len=0 at start: treated as an empty program. Go to DRAIN directly with no valid issue.
- prog_len>DEPTH: clamped to DEPTH.
- reset asserted mid-run: returns to IDLE on the next edge with all outputs at reset values. Buffer contents are preserved.
- issued_cnt increments once per cycle with instr_valid=1.

Test Plan:
1. Basic run: load 8C051234, 00853FE0, 20642345 at indices 0..2, prog_len=3, DRAIN_CYCLES=12, start.
   - instr_valid high for exactly 3 cycles, in that order, with pc_idx 0,1,2.
   - Then 12 NOP cycles, then a single done pulse; issued_cnt=3.
2. Stall: same program, assert stall for 2 cycles while index 1 is presented.
   - 00853FE0 is held for 3 cycles; issued_cnt=3 at done; done arrives 2 cycles later than in scenario 1.
3. Step mode: step_mode=1, prog_len=2, pulse step at cycles 5 and 20.
   - Each word is valid for exactly one cycle after its pulse.
   - Steps with stall=1 are ignored.
   - DRAIN starts after the second issue.
4. Loop and abort: loop_en=1, prog_len=2, run 7 cycles, then assert abort.
   - Sequence issued is A,B,A,B,A,B,A.
   - abort gives NOP on the next cycle; done follows after DRAIN_CYCLES.
   - issued_cnt=7.
5. Reset mid-run at index 1: all outputs are back at reset values next cycle. A new start replays the same program, proving the buffer is retained.
6. Edge cases:
   - prog_len=0 gives no valid issue and done after the drain.
   - load_en while busy leaves the buffer unchanged; verify by rerunning.
   - start during DRAIN is ignored.

Source files
------------

// File: rtl/mips_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mips_instr_sequencer
// Desc   : Loadable program buffer that issues words to the processor instr
//          port in run, single-step or loop mode, followed by a NOP drain tail.
// Rev    : 1.0
// ============================================================================
module mips_instr_sequencer #(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 64,
  parameter int                ADDR_W       = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD     = '0,
  parameter int                DRAIN_CYCLES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              loop_en,
  input  logic              stall,
  input  logic              abort,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_idx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issued_cnt
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      c_DRAIN = 8'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
  logic [7:0]        drain_q, drain_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              w_load_ok;
  logic [ADDR_W:0]   w_eff_len;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_idx;
  logic [ADDR_W:0]   w_issue_len;
  logic              w_issue_loop;
  logic              w_go_drain;

  assign w_load_ok = load_en && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_eff_len = (prog_len > c_DEPTH) ? c_DEPTH : prog_len;

  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    loop_d       = loop_q;
    drain_d      = drain_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    w_issue      = 1'b0;
    w_issue_idx  = idx_q;
    w_issue_len  = len_q;
    w_issue_loop = loop_q;
    w_go_drain   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = w_eff_len;
          loop_d  = loop_en;
          idx_d   = '0;
          cnt_d   = '0;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (w_eff_len == '0) begin
            w_go_drain = 1'b1;
          end else if (step_mode) begin
            state_d = S_STEP;
          end else begin
            state_d      = S_RUN;
            w_issue      = 1'b1;
            w_issue_idx  = '0;
            w_issue_len  = w_eff_len;
            w_issue_loop = loop_en;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_go_drain = 1'b1;
        end else if (!stall) begin
          w_issue = 1'b1;
        end
      end
      S_STEP: begin
        if (abort) begin
          w_go_drain = 1'b1;
        end else if (!stall) begin
          if (step) begin
            w_issue = 1'b1;
          end else begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        if (drain_q == 8'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The write port is bypassed so a same-cycle load+start issues the new word.
    if (w_issue) begin
      if (w_load_ok && (load_addr == w_issue_idx)) begin
        instr_d = load_data;
      end else begin
        instr_d = mem[w_issue_idx];
      end
      valid_d = 1'b1;
      pc_d    = w_issue_idx;
      if (cnt_d != 16'hFFFF) begin
        cnt_d = cnt_d + 16'd1;
      end
      if ({1'b0, w_issue_idx} == (w_issue_len - (ADDR_W+1)'(1))) begin
        idx_d = '0;
        if (!w_issue_loop) begin
          w_go_drain = 1'b1;
        end
      end else begin
        idx_d = w_issue_idx + ADDR_W'(1);
      end
    end

    if (w_go_drain) begin
      state_d = S_DRAIN;
      drain_d = c_DRAIN;
      if (!w_issue) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      drain_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_idx      = pc_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
  assign done        = done_q;
  assign issued_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_instr_sequencer
// Desc   : Directed, table-driven bench for mips_instr_sequencer (DEPTH=8).
// Rev    : 1.0
// ============================================================================
module tb_mips_instr_sequencer;

  localparam int          DEPTH  = 8;
  localparam int          ADDR_W = 3;
  localparam logic [31:0] NOP    = 32'h00000000;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic [ADDR_W:0]   prog_len;
  logic              start, step_mode, step, loop_en, stall, abort;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_idx;
  logic              busy, done;
  logic [15:0]       issued_cnt;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] prog [8];

  typedef struct {
    int          len;
    bit          loop;
    int          stall_at;
    int          stall_n;
    int          abort_at;
    int          poke_at;
    int          n_valid;
    logic [31:0] pcs;
    int          done_cyc;
    int          cnt;
  } run_t;

  run_t tbl [10];

  mips_instr_sequencer #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP), .DRAIN_CYCLES(12)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
    .step_mode(step_mode), .step(step), .loop_en(loop_en), .stall(stall),
    .abort(abort), .instr(instr), .instr_valid(instr_valid), .pc_idx(pc_idx),
    .busy(busy), .done(done), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic run_t mk(input int len, input bit lp, input int sa, input int sn,
                              input int ab, input int pk, input int nv,
                              input logic [31:0] pcs, input int dn, input int cnt);
    run_t r;
    r.len = len; r.loop = lp; r.stall_at = sa; r.stall_n = sn; r.abort_at = ab;
    r.poke_at = pk; r.n_valid = nv; r.pcs = pcs; r.done_cyc = dn; r.cnt = cnt;
    return r;
  endfunction

  // Edge E0 samples start; cycle k is the cycle that follows edge E_k.
  task automatic run_prog(input int ti, input run_t r);
    int nv, done_at, ndone, k, p;
    bit nop_ok, busy_ok;
    logic [15:0] cnt_done;
    nv = 0; done_at = -1; ndone = 0; nop_ok = 1'b1; busy_ok = 1'b1; cnt_done = '0;
    prog_len = 4'(r.len); loop_en = r.loop; step_mode = 1'b0; start = 1'b1;
    k = 0;
    while (k < 60 && (done_at < 0 || k < done_at + 3)) begin
      tick();
      if (instr_valid === 1'b1) begin
        if (nv < r.n_valid) begin
          p = int'(r.pcs[4*nv +: 4]);
          chk($sformatf("run%0d pc#%0d", ti, nv), 64'(pc_idx), 64'(p));
          chk($sformatf("run%0d word#%0d", ti, nv), 64'(instr), 64'(prog[p]));
        end
        nv++;
      end else if (instr !== NOP) begin
        nop_ok = 1'b0;
      end
      if (done === 1'b1) begin
        if (done_at < 0) begin
          done_at  = k;
          cnt_done = issued_cnt;
        end
        ndone++;
      end
      if (busy !== (done_at < 0)) busy_ok = 1'b0;
      k++;
      stall     = (r.stall_at >= 0) && (k >= r.stall_at) && (k < r.stall_at + r.stall_n);
      abort     = (k == r.abort_at);
      start     = (k == r.poke_at);
      load_en   = start;
      load_addr = 3'd1;
      load_data = 32'hDEADBEEF;
    end
    stall = 1'b0; abort = 1'b0; start = 1'b0; load_en = 1'b0;
    chk($sformatf("run%0d valid_cycles", ti), 64'(nv), 64'(r.n_valid));
    chk($sformatf("run%0d done_cycle", ti), 64'(done_at), 64'(r.done_cyc));
    chk($sformatf("run%0d done_pulses", ti), 64'(ndone), 64'd1);
    chk($sformatf("run%0d issued_cnt", ti), 64'(cnt_done), 64'(r.cnt));
    chk($sformatf("run%0d nop_when_invalid", ti), 64'(nop_ok), 64'd1);
    chk($sformatf("run%0d busy_profile", ti), 64'(busy_ok), 64'd1);
  endtask

  initial begin
    int  done_at;
    bit  ok;
    logic [15:0] cnt_done;

    prog[0] = 32'h8C051234; prog[1] = 32'h00853FE0; prog[2] = 32'h20642345;
    prog[3] = 32'hAC450004; prog[4] = 32'h10A0FFFD; prog[5] = 32'h3C08BEEF;
    prog[6] = 32'h01094020; prog[7] = 32'h08000010;

    //          len lp  stl n  abrt poke nv  pcs           done cnt
    tbl[0] = mk(3,  0, -1, 0, -1, -1,  3, 32'h00000210, 15, 3);
    tbl[1] = mk(3,  0,  2, 2, -1, -1,  5, 32'h00021110, 17, 3);
    tbl[2] = mk(2,  1, -1, 0,  7, -1,  7, 32'h00101010, 20, 7);
    tbl[3] = mk(0,  0, -1, 0, -1, -1,  0, 32'h00000000, 13, 0);
    tbl[4] = mk(1,  0, -1, 0, -1, -1,  1, 32'h00000000, 13, 1);
    tbl[5] = mk(12, 0, -1, 0, -1, -1,  8, 32'h76543210, 20, 8);
    tbl[6] = mk(3,  0, -1, 0, -1,  1,  3, 32'h00000210, 15, 3);
    tbl[7] = mk(3,  0, -1, 0, -1,  8,  3, 32'h00000210, 15, 3);
    tbl[8] = mk(3,  0, -1, 0, -1, -1,  3, 32'h00000210, 15, 3);
    tbl[9] = mk(8,  0, -1, 0, -1, -1,  8, 32'h76543210, 20, 8);

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0; loop_en = 1'b0; stall = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst instr", 64'(instr), 64'(NOP));
    chk("rst valid", 64'(instr_valid), 64'd0);
    chk("rst pc", 64'(pc_idx), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst cnt", 64'(issued_cnt), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 3'(i); load_data = prog[i];
      tick();
    end
    load_en = 1'b0;

    for (int t = 0; t < 10; t++) begin
      run_prog(t, tbl[t]);
    end

    // Single-step: pulses at E5 and E20, a stalled pulse at E10 is ignored.
    prog_len = 4'd2; loop_en = 1'b0; step_mode = 1'b1; start = 1'b1;
    ok = 1'b1; done_at = -1; cnt_done = '0;
    for (int k = 0; k < 45; k++) begin
      tick();
      start = 1'b0;
      if (instr_valid !== ((k == 5) || (k == 20))) ok = 1'b0;
      if (k == 5) begin
        chk("step word0", 64'(instr), 64'(prog[0]));
        chk("step pc0", 64'(pc_idx), 64'd0);
      end
      if (k == 20) begin
        chk("step word1", 64'(instr), 64'(prog[1]));
        chk("step pc1", 64'(pc_idx), 64'd1);
      end
      if (k == 21) chk("step drain busy", 64'(busy), 64'd1);
      if (done === 1'b1 && done_at < 0) begin
        done_at  = k;
        cnt_done = issued_cnt;
      end
      step  = (k + 1 == 5) || (k + 1 == 10) || (k + 1 == 20);
      stall = (k + 1 == 10);
    end
    step = 1'b0; stall = 1'b0; step_mode = 1'b0;
    chk("step valid profile", 64'(ok), 64'd1);
    chk("step done_cycle", 64'(done_at), 64'd33);
    chk("step issued_cnt", 64'(cnt_done), 64'd2);

    // Reset while index 1 is presented, then replay from the retained buffer.
    prog_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("midrst pre pc", 64'(pc_idx), 64'd1);
    reset = 1'b1;
    tick();
    chk("midrst instr", 64'(instr), 64'(NOP));
    chk("midrst valid", 64'(instr_valid), 64'd0);
    chk("midrst pc", 64'(pc_idx), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst cnt", 64'(issued_cnt), 64'd0);
    reset = 1'b0;
    run_prog(10, tbl[0]);

    // Load and start in the same cycle: the new word is the one issued.
    load_en = 1'b1; load_addr = 3'd0; load_data = 32'h3C01ABCD; prog_len = 4'd1; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("ldstart valid", 64'(instr_valid), 64'd1);
    chk("ldstart word", 64'(instr), 64'h3C01ABCD);
    chk("ldstart pc", 64'(pc_idx), 64'd0);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (done === 1'b1) ok = 1'b1;
    end
    chk("ldstart done seen", 64'(ok), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
